// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating stall counter for performance monitoring.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ControlUnitOut,
    input  logic             Branch,
    input  logic             Jump,
    input  logic [5:0]       Opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_shamt,
    input  logic [5:0]       id_funct,
    input  logic [31:0]      id_rd1,
    input  logic [31:0]      id_rd2,
    input  logic [31:0]      id_imm,
    input  logic [31:0]      id_pc4,
    input  logic             flush,
    output logic [7:0]       ex_ctrl,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_shamt,
    output logic [5:0]       ex_funct,
    output logic [31:0]      ex_rd1,
    output logic [31:0]      ex_rd2,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pc4,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    logic [7:0]       ctrl_q, ctrl_d;
    logic             branch_q, branch_d;
    logic             jump_q, jump_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [4:0]       rd_q, rd_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [5:0]       funct_q, funct_d;
    logic [31:0]      rd1_q, rd1_d;
    logic [31:0]      rd2_q, rd2_d;
    logic [31:0]      imm_q, imm_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic uses_rt;
    logic hazard;
    logic bubble;

    always_comb begin
        uses_rt = 1'b0;
        case (Opcode)
            OP_RTYPE, OP_SW, OP_BEQ: uses_rt = 1'b1;
            default:                 uses_rt = 1'b0;
        endcase
    end

    // $zero is never written, so a load targeting r0 cannot create a dependency.
    always_comb begin
        hazard = ctrl_q[3] && (rt_q != 5'd0) &&
                 ((rt_q == id_rs) || (uses_rt && (rt_q == id_rt)));
    end

    assign bubble     = flush | hazard;
    assign pc_write   = flush | ~hazard;
    assign ifid_write = flush | ~hazard;

    always_comb begin
        ctrl_d   = ControlUnitOut;
        branch_d = Branch;
        jump_d   = Jump;
        rs_d     = id_rs;
        rt_d     = id_rt;
        rd_d     = id_rd;
        shamt_d  = id_shamt;
        funct_d  = id_funct;
        rd1_d    = id_rd1;
        rd2_d    = id_rd2;
        imm_d    = id_imm;
        pc4_d    = id_pc4;
        stall_d  = stall_q;
        if (bubble) begin
            ctrl_d   = 8'd0;
            branch_d = 1'b0;
            jump_d   = 1'b0;
        end
        // A flushed cycle is not a stall even if a hazard was also present.
        if (hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= 8'd0;
            branch_q <= 1'b0;
            jump_q   <= 1'b0;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            shamt_q  <= 5'd0;
            funct_q  <= 6'd0;
            rd1_q    <= 32'd0;
            rd2_q    <= 32'd0;
            imm_q    <= 32'd0;
            pc4_q    <= 32'd0;
            stall_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            branch_q <= branch_d;
            jump_q   <= jump_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            shamt_q  <= shamt_d;
            funct_q  <= funct_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            pc4_q    <= pc4_d;
            stall_q  <= stall_d;
        end
    end

    assign ex_ctrl     = ctrl_q;
    assign ex_branch   = branch_q;
    assign ex_jump     = jump_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign ex_shamt    = shamt_q;
    assign ex_funct    = funct_q;
    assign ex_rd1      = rd1_q;
    assign ex_rd2      = rd2_q;
    assign ex_imm      = imm_q;
    assign ex_pc4      = pc4_q;
    assign stall_count = stall_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It sits directly downstream of the control unit and register file. It captures the 8-bit control word, Branch/Jump, operands and instruction fields every cycle and presents them to the EX stage. When a load in EX feeds the instruction in ID, it stalls PC and IF/ID, inserts a bubble, and counts stalls for performance monitoring.

## Interface
- CNT_W, 16, width of saturating stall counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ControlUnitOut  in  8  {RegDst, ALUOp[1:0], ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg} from control unit
- Branch, Jump  in  1 each  from control unit
- Opcode  in  6  ID instruction [31:26]
- id_rs, id_rt, id_rd  in  5 each  ID instruction fields
- id_shamt  in  5; id_funct  in  6
- id_rd1, id_rd2  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_pc4  in  32  PC+4 of ID instruction
- flush  in  1  squash ID instruction (taken branch/jump resolved downstream)
- ex_ctrl  out  8  registered control word, same bit order as ControlUnitOut
- ex_branch, ex_jump  out  1 each
- ex_rs, ex_rt, ex_rd, ex_shamt  out  5 each; ex_funct  out  6
- ex_rd1, ex_rd2, ex_imm, ex_pc4  out  32 each
- pc_write  out  1  0 = hold PC this cycle
- ifid_write  out  1  0 = hold IF/ID this cycle
- stall_count  out  CNT_W  number of stall cycles since reset, saturating

## Operation
- Hazard detect (combinational from registered EX state and current ID inputs): hazard = ex_ctrl[3] (MemRead) AND ex_rt != 0 AND (ex_rt == id_rs OR (uses_rt AND ex_rt == id_rt)).
- uses_rt = 1 for Opcode 0 (R-format), 43 (SW), 4 (BEQ); 0 for 9 (ADDIU), 35 (LW), 2 (J), all others.
- ex_rt == 0 never raises hazard ($zero is never written).
- pc_write = ifid_write = ~hazard, with one exception: when flush=1 both are 1, because the squashed instruction must not hold the front end.
- Register update priority at each posedge: rst > flush > hazard > normal.
  - rst: all ex_* outputs 0, stall_count 0.
  - flush: bubble. ex_ctrl=0, ex_branch=ex_jump=0; data/field outputs loaded normally (don't-care).
  - hazard: bubble as above; stall_count increments.
  - normal: every ex_* output loads its id_* / control counterpart.
- A bubble always forces RegWrite, MemRead, MemWrite, Branch and Jump to 0. Unknown bits in ControlUnitOut (SW/BEQ don't-cares) pass through unchanged in the normal case.
- stall_count increments by 1 per hazard cycle not overridden by flush. It saturates at 2^CNT_W−1 and never wraps.
- Load-use with one intervening bubble: after the bubble, ex_ctrl[3]=0, so hazard drops and the held ID instruction advances. A stall therefore lasts exactly 1 cycle per load-use pair.

## Timing
- All ex_* outputs and stall_count are registered; latency ID → EX is 1 cycle.
- pc_write and ifid_write are combinational, valid in the same cycle as the ID inputs, and consumed at the next posedge.
- Reset values: ex_* = 0, stall_count = 0. pc_write = ifid_write = 1 while rst is held, because ex_ctrl = 0.
- Reset asserted mid-stall clears the pending bubble state. The first cycle after rst deasserts is a normal load.
- flush and hazard in the same cycle: bubble inserted, no stall counted, pc_write = ifid_write = 1.
- Back-to-back loads (LW then dependent LW): exactly 1 stall, then normal flow.

## Test plan
- Reset: hold rst 2 cycles with random inputs → all ex_* = 0, stall_count = 0, pc_write = 1.
- Pass-through: R-format, ControlUnitOut=8'b11000010, rd1=32'h1234, rs=5, rt=6, rd=7 → next cycle ex_ctrl=8'hC2, ex_rd1=32'h1234, ex_rd=7; pc_write=1.
- Load-use: LW (8'b00011011, rt=8) then ADD using rs=8 → during ADD in ID, pc_write=ifid_write=0. Next cycle ex_ctrl=0 and stall_count=1. Following cycle ex_ctrl=8'hC2 (ADD advances).
- No false hazard: LW rt=8, then ADDIU rt=8 rs=3 → no stall. LW rt=0, then ADD rs=0 → no stall.
- Flush vs hazard: LW rt=4 in EX, BEQ rs=4 in ID, flush=1 → ex_ctrl=0, ex_branch=0, stall_count unchanged, pc_write=1.
- Saturation: CNT_W=2, 5 load-use pairs → stall_count stops at 3.
